// File: rtl/acc_core_sequencer.sv
// acc_core_sequencer: run control, retired-instruction counter and host/core instruction-memory arbiter.
module acc_core_sequencer #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_wr_valid,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ready,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_stop,
  input  logic              core_fetch_req,
  input  logic [ADDR_W-1:0] core_fetch_addr,
  output logic              core_fetch_gnt,
  output logic              core_fetch_rvalid,
  input  logic              core_instr_done,
  input  logic              core_halt,
  output logic              core_en,
  output logic              core_restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        state,
  output logic [15:0]       instr_count
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [2:0] {IDLE, RUN, STEP, PAUSED, HALTED} state_t;
  state_t cur, nxt;
  logic restart_next, restart_q, rvalid_q, active, nxt_active, host_gnt;
  logic [SW-1:0] starve_cnt;
  assign active     = cur == RUN || cur == STEP;
  assign nxt_active = nxt == RUN || nxt == STEP;
  always_comb begin
    nxt = cur;
    restart_next = 1'b0;
    case (cur)
      IDLE, PAUSED: if (!cmd_stop && (cmd_step || cmd_run)) begin
        nxt = cmd_step ? STEP : RUN;
        restart_next = cur == IDLE;
      end
      RUN:    nxt = core_halt ? HALTED : cmd_stop ? PAUSED : RUN;
      STEP:   nxt = core_halt ? HALTED : (cmd_stop || core_instr_done) ? PAUSED : STEP;
      HALTED: if (cmd_run) begin
        nxt = RUN;
        restart_next = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end
  // The host only loses while the core is fetching and has not yet been starved out.
  assign core_fetch_gnt    = active && core_fetch_req && starve_cnt < SW'(STARVE_MAX);
  assign host_wr_ready     = !core_fetch_gnt;
  assign host_gnt          = host_wr_valid && host_wr_ready;
  assign mem_we            = host_gnt;
  assign mem_addr          = host_gnt ? host_wr_addr : core_fetch_gnt ? core_fetch_addr : '0;
  assign mem_wdata         = host_gnt ? host_wr_data : '0;
  assign core_en           = active;
  assign core_restart      = restart_q;
  assign core_fetch_rvalid = rvalid_q;
  assign state             = cur;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= IDLE;
      restart_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      starve_cnt  <= '0;
      instr_count <= '0;
    end else begin
      cur         <= nxt;
      restart_q   <= restart_next;
      rvalid_q    <= core_fetch_gnt;
      starve_cnt  <= (active && nxt_active && host_wr_valid && !host_wr_ready) ? starve_cnt + 1'b1 : '0;
      instr_count <= restart_next ? '0 :
                     (active && core_instr_done && instr_count != 16'hFFFF) ? instr_count + 16'd1 : instr_count;
    end
  end
endmodule

// File: tb/tb_acc_core_sequencer.sv
// tb_acc_core_sequencer: scoreboard bench for memory writes and fetch data plus run-control checks.
module tb_acc_core_sequencer;
  localparam int AW = 5;
  localparam int DW = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic host_wr_valid, host_wr_ready, cmd_run, cmd_step, cmd_stop;
  logic [AW-1:0] host_wr_addr, core_fetch_addr, mem_addr;
  logic [DW-1:0] host_wr_data, mem_wdata, mem_rdata;
  logic core_fetch_req, core_fetch_gnt, core_fetch_rvalid, core_instr_done, core_halt;
  logic core_en, core_restart, mem_we;
  logic [2:0] state;
  logic [15:0] instr_count;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] exp_mem [32];
  logic [DW-1:0] prog [5] = '{8'h01, 8'h05, 8'h02, 8'h03, 8'h0A};
  logic [AW+DW-1:0] wq [$];
  logic [DW-1:0] fq [$];
  logic [AW+DW-1:0] w_exp;
  logic [DW-1:0] f_exp;
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  acc_core_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_wr_ready(host_wr_ready),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_stop(cmd_stop),
    .core_fetch_req(core_fetch_req), .core_fetch_addr(core_fetch_addr),
    .core_fetch_gnt(core_fetch_gnt), .core_fetch_rvalid(core_fetch_rvalid),
    .core_instr_done(core_instr_done), .core_halt(core_halt),
    .core_en(core_en), .core_restart(core_restart),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state(state), .instr_count(instr_count)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Scoreboard consumer: pops expected writes and fetch words as the DUT produces them.
  always @(negedge clk) if (rst_n) begin
    vecs++;
    if (host_wr_ready && core_fetch_gnt) begin
      errs++;
      $display("FAIL exclusive_grant: ready=%0b gnt=%0b required not both 1", host_wr_ready, core_fetch_gnt);
    end
    if (core_fetch_rvalid) begin
      vecs++;
      if (fq.size() == 0) begin
        errs++;
        $display("FAIL fetch_unexpected: rvalid with data %0h, none expected", mem_rdata);
      end else begin
        f_exp = fq.pop_front();
        if (mem_rdata !== f_exp) begin
          errs++;
          $display("FAIL fetch_data: got %0h expected %0h", mem_rdata, f_exp);
        end
      end
    end
    if (core_fetch_gnt) fq.push_back(exp_mem[core_fetch_addr]);
    if (mem_we) begin
      vecs++;
      if (wq.size() == 0) begin
        errs++;
        $display("FAIL write_unexpected: addr %0h data %0h", mem_addr, mem_wdata);
      end else begin
        w_exp = wq.pop_front();
        if ({mem_addr, mem_wdata} !== w_exp) begin
          errs++;
          $display("FAIL write_port: got addr/data %0h expected %0h", {mem_addr, mem_wdata}, w_exp);
        end
      end
    end
  end

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic r, input logic s, input logic p);
    cmd_run = r; cmd_step = s; cmd_stop = p;
    step_clk();
    cmd_run = 0; cmd_step = 0; cmd_stop = 0;
  endtask

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_wr_valid = 1; host_wr_addr = a; host_wr_data = d;
    wq.push_back({a, d});
    exp_mem[a] = d;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    bit got = 0;
    core_fetch_req = 1; core_fetch_addr = a;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (core_fetch_gnt) begin got = 1; break; end
      step_clk();
    end
    vecs++;
    if (!got || mem_addr !== a || mem_we !== 1'b0) begin
      errs++;
      $display("FAIL fetch_grant: got gnt=%0b addr=%0h we=%0b expected gnt=1 addr=%0h we=0", got, mem_addr, mem_we, a);
    end
    step_clk();
    core_fetch_req = 0;
    @(negedge clk);
    vecs++;
    if (core_fetch_rvalid !== 1'b1) begin
      errs++;
      $display("FAIL fetch_rvalid: got %0b expected 1", core_fetch_rvalid);
    end
    step_clk();
  endtask

  task automatic retire(input logic h);
    core_instr_done = 1; core_halt = h;
    step_clk();
    core_instr_done = 0; core_halt = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    @(negedge clk);
    vecs++;
    if ({state, core_en, core_restart, core_fetch_gnt, core_fetch_rvalid, host_wr_ready, mem_we, instr_count}
        !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0}) begin
      errs++;
      $display("FAIL reset_values: state=%0d en=%0b rst=%0b gnt=%0b rv=%0b rdy=%0b we=%0b cnt=%0d",
               state, core_en, core_restart, core_fetch_gnt, core_fetch_rvalid, host_wr_ready, mem_we, instr_count);
    end
    step_clk();
    rst_n = 1;
    step_clk();
  endtask

  task automatic test_load;
    for (int i = 0; i < 5; i++) begin
      push_write(AW'(i), prog[i]);
      @(negedge clk);
      vecs++;
      if (host_wr_ready !== 1'b1) begin
        errs++;
        $display("FAIL idle_ready[%0d]: got %0b expected 1", i, host_wr_ready);
      end
      step_clk();
      host_wr_valid = 0;
    end
    vecs++;
    if (wq.size() != 0) begin
      errs++;
      $display("FAIL load_writes: %0d writes missing, expected 0", wq.size());
    end
  endtask

  task automatic test_run_program;
    cmd(1, 0, 0);
    @(negedge clk);
    vecs++;
    if ({state, core_restart, core_en} !== {3'd1, 1'b1, 1'b1}) begin
      errs++;
      $display("FAIL run_entry: state=%0d restart=%0b en=%0b expected 1/1/1", state, core_restart, core_en);
    end
    step_clk();
    @(negedge clk);
    vecs++;
    if (core_restart !== 1'b0) begin
      errs++;
      $display("FAIL restart_width: got %0b expected 0", core_restart);
    end
    step_clk();
    fetch(0); fetch(1); retire(0);
    fetch(2); fetch(3); retire(0);
    fetch(4); retire(1);
    @(negedge clk);
    vecs++;
    if ({state, core_en, instr_count} !== {3'd4, 1'b0, 16'd3}) begin
      errs++;
      $display("FAIL program_halt: state=%0d en=%0b cnt=%0d expected 4/0/3", state, core_en, instr_count);
    end
    step_clk();
  endtask

  task automatic test_starvation;
    int n = 0;
    logic exp_r;
    cmd(1, 0, 0);
    @(negedge clk);
    vecs++;
    if ({state, core_restart, instr_count} !== {3'd1, 1'b1, 16'd0}) begin
      errs++;
      $display("FAIL halted_rerun: state=%0d restart=%0b cnt=%0d expected 1/1/0", state, core_restart, instr_count);
    end
    step_clk();
    core_fetch_req = 1; core_fetch_addr = 0;
    push_write(5'd16, 8'hA0);
    for (int c = 0; c < 10; c++) begin
      exp_r = (c % 5 == 4);
      @(negedge clk);
      vecs++;
      if (host_wr_ready !== exp_r || core_fetch_gnt !== !exp_r) begin
        errs++;
        $display("FAIL starve_cycle%0d: ready=%0b gnt=%0b expected ready=%0b", c, host_wr_ready, core_fetch_gnt, exp_r);
      end
      step_clk();
      if (exp_r && c < 9) begin
        n++;
        push_write(AW'(16 + n), DW'(8'hA0 + n));
      end
    end
    host_wr_valid = 0; core_fetch_req = 0;
    @(negedge clk);
    vecs++;
    if (wq.size() != 0 || fq.size() != 0) begin
      errs++;
      $display("FAIL starve_drain: %0d writes, %0d fetches pending, expected 0", wq.size(), fq.size());
    end
    step_clk();
  endtask

  task automatic test_step;
    logic [15:0] c0;
    cmd(0, 0, 1);
    @(negedge clk);
    vecs++;
    if (state !== 3'd3) begin
      errs++;
      $display("FAIL stop_pause: state=%0d expected 3", state);
    end
    c0 = instr_count;
    step_clk();
    cmd(0, 1, 0);
    @(negedge clk);
    vecs++;
    if ({state, core_en, core_restart} !== {3'd2, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL step_entry: state=%0d en=%0b restart=%0b expected 2/1/0", state, core_en, core_restart);
    end
    step_clk(); step_clk();
    @(negedge clk);
    vecs++;
    if ({state, core_en} !== {3'd2, 1'b1}) begin
      errs++;
      $display("FAIL step_hold: state=%0d en=%0b expected 2/1", state, core_en);
    end
    step_clk();
    retire(0);
    @(negedge clk);
    vecs++;
    if ({state, instr_count} !== {3'd3, c0 + 16'd1}) begin
      errs++;
      $display("FAIL step_retire: state=%0d cnt=%0d expected 3/%0d", state, instr_count, c0 + 16'd1);
    end
    step_clk();
    cmd(1, 0, 0);
    @(negedge clk);
    vecs++;
    if ({state, core_restart} !== {3'd1, 1'b0}) begin
      errs++;
      $display("FAIL resume_run: state=%0d restart=%0b expected 1/0", state, core_restart);
    end
    step_clk();
    cmd(1, 1, 1);
    @(negedge clk);
    vecs++;
    if (state !== 3'd3) begin
      errs++;
      $display("FAIL cmd_priority: state=%0d expected 3", state);
    end
    step_clk();
  endtask

  task automatic test_halt_stop;
    cmd(1, 0, 0);
    core_halt = 1; cmd_stop = 1;
    step_clk();
    core_halt = 0; cmd_stop = 0;
    @(negedge clk);
    vecs++;
    if (state !== 3'd4) begin
      errs++;
      $display("FAIL halt_over_stop: state=%0d expected 4", state);
    end
    step_clk();
    cmd(0, 1, 1);
    @(negedge clk);
    vecs++;
    if ({state, core_en} !== {3'd4, 1'b0}) begin
      errs++;
      $display("FAIL halted_ignore: state=%0d en=%0b expected 4/0", state, core_en);
    end
    step_clk();
    cmd(1, 0, 0);
    @(negedge clk);
    vecs++;
    if ({state, core_restart, core_en, instr_count} !== {3'd1, 1'b1, 1'b1, 16'd0}) begin
      errs++;
      $display("FAIL halt_restart: state=%0d restart=%0b en=%0b cnt=%0d expected 1/1/1/0",
               state, core_restart, core_en, instr_count);
    end
    step_clk();
  endtask

  task automatic test_reset_mid;
    core_fetch_req = 1; core_fetch_addr = 1;
    @(negedge clk);
    vecs++;
    if (core_fetch_gnt !== 1'b1) begin
      errs++;
      $display("FAIL mid_grant: got %0b expected 1", core_fetch_gnt);
    end
    step_clk();
    core_fetch_req = 0;
    vecs++;
    if (core_fetch_rvalid !== 1'b1) begin
      errs++;
      $display("FAIL mid_rvalid: got %0b expected 1", core_fetch_rvalid);
    end
    rst_n = 0;
    #1;
    vecs++;
    if ({state, core_en, core_restart, core_fetch_gnt, core_fetch_rvalid, host_wr_ready, mem_we, instr_count}
        !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0}) begin
      errs++;
      $display("FAIL async_reset: state=%0d en=%0b rst=%0b gnt=%0b rv=%0b rdy=%0b we=%0b cnt=%0d",
               state, core_en, core_restart, core_fetch_gnt, core_fetch_rvalid, host_wr_ready, mem_we, instr_count);
    end
    fq.delete();
    step_clk();
    rst_n = 1;
    step_clk();
  endtask

  initial begin
    host_wr_valid = 0; host_wr_addr = 0; host_wr_data = 0;
    cmd_run = 0; cmd_step = 0; cmd_stop = 0;
    core_fetch_req = 0; core_fetch_addr = 0; core_instr_done = 0; core_halt = 0;
    for (int i = 0; i < 32; i++) begin mem[i] = '0; exp_mem[i] = '0; end
    test_reset();
    test_load();
    test_run_program();
    test_starvation();
    test_step();
    test_halt_stop();
    test_reset_mid();
    vecs++;
    if (wq.size() != 0 || fq.size() != 0) begin
      errs++;
      $display("FAIL final_drain: %0d writes, %0d fetches pending, expected 0", wq.size(), fq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/acc_core_sequencer.md
# acc_core_sequencer

Run controller and instruction-memory arbiter for the 8-bit accumulator core. It owns the single-port 32x8 instruction memory and shares it between the host loader and the core's fetch port, with bounded starvation for the host. It also sequences the core through idle, run, single-step, pause and halt, and counts retired instructions. It sits between the top-level pin decode and the core/memory pair.

## Interface
- ADDR_W, 5, instruction-memory address width (32 entries)
- DATA_W, 8, memory word width
- STARVE_MAX, 4, consecutive denied host cycles in RUN/STEP before the host is forced a grant
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- host_wr_valid  input  1  host requests a write
- host_wr_addr  input  ADDR_W  host write address
- host_wr_data  input  DATA_W  host write data
- host_wr_ready  output  1  host write accepted this cycle (valid & ready = write)
- cmd_run, cmd_step, cmd_stop  input  1 each  run-control commands, single-cycle pulses
- core_fetch_req  input  1  core requests a fetch at core_fetch_addr
- core_fetch_addr  input  ADDR_W  core fetch address
- core_fetch_gnt  output  1  fetch issued to memory this cycle
- core_fetch_rvalid  output  1  mem_rdata holds the granted fetch word
- core_instr_done  input  1  core retired an instruction (EXECUTE cycle)
- core_halt  input  1  core executed HALT or an illegal opcode
- core_en  output  1  core clock enable
- core_restart  output  1  one-cycle pulse: core clears PC/AC/state
- mem_we, mem_addr[ADDR_W], mem_wdata[DATA_W]  output  memory port; mem_rdata[DATA_W] input, 1-cycle read latency
- state  output  3  IDLE=0, RUN=1, STEP=2, PAUSED=3, HALTED=4
- instr_count  output  16  retired instructions, saturating at 0xFFFF

## Operation
- Run-control states:
  - IDLE: cmd_step -> STEP, otherwise cmd_run -> RUN; either pulses core_restart.
  - RUN: cmd_stop -> PAUSED.
  - STEP: core_instr_done -> PAUSED; cmd_stop -> PAUSED.
  - PAUSED: cmd_step -> STEP, otherwise cmd_run -> RUN; no restart.
  - HALTED: cmd_run -> RUN with core_restart; cmd_step and cmd_stop ignored.
- Same-cycle command priority is stop > step > run. core_halt in RUN/STEP -> HALTED and overrides every command in that cycle.
- core_en = 1 only in RUN and STEP; core_instr_done and core_halt are ignored in all other states.
- instr_count increments on core_instr_done while core_en = 1, saturates at 0xFFFF, and clears on core_restart.
- Arbitration in IDLE/PAUSED/HALTED: host_wr_ready = 1 and core_fetch_gnt = 0.
- Arbitration in RUN/STEP:
  - Core wins when core_fetch_req = 1 and starve_cnt < STARVE_MAX.
  - Host wins when the core is not requesting, or when starve_cnt = STARVE_MAX. In the second case core_fetch_gnt = 0 and the core stalls one cycle.
- starve_cnt increments on each cycle with host_wr_valid & !host_wr_ready. It clears on any host grant, on host_wr_valid = 0, and on leaving RUN/STEP.
- Memory port drive:
  - Host grant: mem_we = 1, mem_addr = host_wr_addr, mem_wdata = host_wr_data.
  - Core grant: mem_we = 0, mem_addr = core_fetch_addr.
  - Idle: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- host_wr_ready and core_fetch_gnt are never both 1.

## Timing
- Reset values:
  - state = IDLE, core_en = 0, core_restart = 0, core_fetch_gnt = 0, core_fetch_rvalid = 0.
  - host_wr_ready = 1, which is combinational from the IDLE state.
  - mem_we = 0, instr_count = 0, starve_cnt = 0.
- Reset asserted mid-operation aborts any pending rvalid and returns the block to IDLE; memory contents are untouched.
- Grants and mem_* are combinational from the current state, the requests and starve_cnt.
- core_fetch_rvalid is registered: it is 1 the cycle after core_fetch_gnt.
- State changes take effect on the clock edge after the command. core_restart is high for exactly the first cycle of the new RUN/STEP state, with core_en = 1 in that cycle.
- A fetch granted in the last cycle of RUN/STEP still returns core_fetch_rvalid the next cycle.
- Host worst-case wait in RUN is STARVE_MAX cycles, with a grant on cycle STARVE_MAX+1.

## Test plan
- Reset, then host writes 0x01,0x05,0x02,0x03,0x0A to addresses 0..4 in IDLE -> ready = 1 every cycle, mem_we pulses 5 times with matching addr/data.
- cmd_run -> next cycle state = 1, core_restart high one cycle, core_en = 1. After the core fetches and retires LOAD 5, ADD 3, HALT -> state = 4, core_en = 0, instr_count = 3.
- In RUN with core_fetch_req held at 1 and host_wr_valid held at 1 -> host denied 4 cycles, granted on the 5th with core_fetch_gnt = 0 that cycle, then the pattern repeats.
- cmd_step from PAUSED -> core_en = 1 until core_instr_done, then state = 3 and instr_count +1 without restart. cmd_stop, cmd_step and cmd_run together in RUN -> PAUSED.
- core_halt and cmd_stop in the same cycle -> HALTED. Then cmd_step -> no change; cmd_run -> RUN with core_restart and instr_count = 0.
- rst_n asserted mid-RUN one cycle after a fetch grant -> core_fetch_rvalid = 0 and all outputs at reset values asynchronously.
